// File: rtl/count_pkg.sv
// Shared definitions for the 32-lane h+/h- counter and its downstream
// count_accum reducer.
package count_pkg;

   localparam int unsigned COUNT_LANES  = 32;
   localparam int unsigned COUNT_LANE_W = 7;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      HOLD
   } count_acc_state_t;

   // Minimum accumulator width able to hold max_beats full-scale lane counts.
   function automatic int unsigned acc_width(input int unsigned max_beats);
      return COUNT_LANE_W + $clog2(max_beats);
   endfunction

endpackage

// File: rtl/count_accum.sv
// count_accum: accumulates per-beat h+/h- counts over a group of up to
// MAX_BEATS beats (closed by in_last or force-closed at MAX_BEATS), then
// presents totals, signed difference and beat count via a held handshake.
// Optional macro COUNT_ACCUM_THRESH_EN adds a thresh input and a fire output.
module count_accum
   import count_pkg::*;
#(
   parameter  int unsigned MAX_BEATS = 16,
   parameter  int unsigned ACC_W     = 11,
   localparam int unsigned BEAT_W    = $clog2(MAX_BEATS + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_last,
   input  logic [COUNT_LANE_W-1:0] h_plus_32,
   input  logic [COUNT_LANE_W-1:0] h_minus_32,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ACC_W-1:0]        sum_plus,
   output logic [ACC_W-1:0]        sum_minus,
   output logic signed [ACC_W:0]   diff,
   output logic [BEAT_W-1:0]       beats,
   output logic                    overrun
`ifdef COUNT_ACCUM_THRESH_EN
   ,
   input  logic signed [ACC_W:0]   thresh,
   output logic                    fire
`endif
);

   if (ACC_W < acc_width(MAX_BEATS)) begin : g_bad_acc_w
      $error("count_accum: ACC_W too small for MAX_BEATS");
   end

   count_acc_state_t       state_q;
   logic [ACC_W-1:0]       acc_p_q, acc_p_d;
   logic [ACC_W-1:0]       acc_m_q, acc_m_d;
   logic [BEAT_W-1:0]      cnt_q, cnt_d;
   logic                   out_valid_q;
   logic [ACC_W-1:0]       sum_plus_q, sum_minus_q;
   logic signed [ACC_W:0]  diff_q, diff_d;
   logic [BEAT_W-1:0]      beats_q;
   logic                   overrun_q;
   logic                   accept, close;

   // Handshake decode and next totals including the beat being accepted.
   always_comb begin
      in_ready = (state_q != HOLD);
      accept   = in_valid && in_ready;
      acc_p_d  = acc_p_q + ACC_W'(h_plus_32);
      acc_m_d  = acc_m_q + ACC_W'(h_minus_32);
      cnt_d    = cnt_q + BEAT_W'(1);
      close    = accept && (in_last || (cnt_d == BEAT_W'(MAX_BEATS)));
      diff_d   = $signed({1'b0, acc_p_d}) - $signed({1'b0, acc_m_d});
   end

   // Group FSM with accumulators and registered result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_p_q     <= '0;
         acc_m_q     <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         sum_plus_q  <= '0;
         sum_minus_q <= '0;
         diff_q      <= '0;
         beats_q     <= '0;
         overrun_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc_p_q <= acc_p_d;
                  acc_m_q <= acc_m_d;
                  cnt_q   <= cnt_d;
                  if (close) begin
                     state_q     <= HOLD;
                     out_valid_q <= 1'b1;
                     sum_plus_q  <= acc_p_d;
                     sum_minus_q <= acc_m_d;
                     diff_q      <= diff_d;
                     beats_q     <= cnt_d;
                     overrun_q   <= !in_last;
                  end else begin
                     state_q <= ACCUM;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  acc_p_q     <= '0;
                  acc_m_q     <= '0;
                  cnt_q       <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef COUNT_ACCUM_THRESH_EN
   logic fire_q;

   // Threshold compare registered alongside diff on the closing beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fire_q <= 1'b0;
      end else if (close) begin
         fire_q <= (diff_d >= thresh);
      end
   end

   assign fire = fire_q;
`endif

   assign out_valid = out_valid_q;
   assign sum_plus  = sum_plus_q;
   assign sum_minus = sum_minus_q;
   assign diff      = diff_q;
   assign beats     = beats_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_count_accum.sv
// Testbench for count_accum: directed scenarios plus randomized groups,
// checked against a running-sum reference model of the group rules.
module tb_count_accum;

   localparam int MAX_BEATS = 16;
   localparam int ACC_W     = 11;
   localparam int BEAT_W    = $clog2(MAX_BEATS + 1);

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  in_valid, in_ready, in_last;
   logic [6:0]            h_plus_32, h_minus_32;
   logic                  out_valid, out_ready;
   logic [ACC_W-1:0]      sum_plus, sum_minus;
   logic signed [ACC_W:0] diff;
   logic [BEAT_W-1:0]     beats;
   logic                  overrun;
`ifdef COUNT_ACCUM_THRESH_EN
   logic signed [ACC_W:0] thresh;
   logic                  fire;
`endif

   always #5 clk = ~clk;

   count_accum #(.MAX_BEATS(MAX_BEATS), .ACC_W(ACC_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_last    (in_last),
      .h_plus_32  (h_plus_32),
      .h_minus_32 (h_minus_32),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .sum_plus   (sum_plus),
      .sum_minus  (sum_minus),
      .diff       (diff),
      .beats      (beats),
      .overrun    (overrun)
`ifdef COUNT_ACCUM_THRESH_EN
      ,
      .thresh     (thresh),
      .fire       (fire)
`endif
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: running group totals and the expected held result.
   int g_p, g_m, g_n;
   int r_p, r_m, r_d, r_n, r_ov, r_fire;
   int thr;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_result();
      chk("out_valid", out_valid, 1);
      chk("sum_plus", sum_plus, r_p);
      chk("sum_minus", sum_minus, r_m);
      chk("diff", diff, r_d);
      chk("beats", beats, r_n);
      chk("overrun", overrun, r_ov);
`ifdef COUNT_ACCUM_THRESH_EN
      chk("fire", fire, r_fire);
`endif
   endtask

   task automatic scramble_idle_inputs();
      in_valid   = 1'b0;
      in_last    = 1'($urandom_range(0, 1));
      h_plus_32  = 7'($urandom_range(0, 127));
      h_minus_32 = 7'($urandom_range(0, 127));
   endtask

   // Present one beat; it must be accepted at the next edge.
   task automatic beat(input int p, input int m, input bit last, output bit closed);
      in_valid   = 1'b1;
      h_plus_32  = 7'(p);
      h_minus_32 = 7'(m);
      in_last    = last;
`ifdef COUNT_ACCUM_THRESH_EN
      thresh     = (ACC_W+1)'(thr);
`endif
      chk("in_ready_beat", in_ready, 1);
      @(posedge clk); #1;
      scramble_idle_inputs();
      g_p += p;
      g_m += m;
      g_n++;
      closed = last || (g_n == MAX_BEATS);
      if (closed) begin
         r_p    = g_p;
         r_m    = g_m;
         r_d    = g_p - g_m;
         r_n    = g_n;
         r_ov   = last ? 0 : 1;
         r_fire = (r_d >= thr) ? 1 : 0;
         check_result();
      end else begin
         chk("open_out_valid", out_valid, 0);
      end
   endtask

   // Idle cycles with garbage data and in_valid low; nothing may change.
   task automatic idle(input int n);
      repeat (n) begin
         scramble_idle_inputs();
         @(posedge clk); #1;
         chk("idle_out_valid", out_valid, 0);
         chk("idle_in_ready", in_ready, 1);
      end
   endtask

   // Hold the result for 'hold' cycles with a beat pending, then take it.
   task automatic release_result(input int hold, input bit pend,
                                 input int p, input int m, input bit last);
      in_valid   = 1'b1;
      h_plus_32  = 7'(p);
      h_minus_32 = 7'(m);
      in_last    = last;
      out_ready  = 1'b0;
      repeat (hold) begin
         @(posedge clk); #1;
         chk("hold_in_ready", in_ready, 0);
         check_result();
      end
      in_valid  = pend;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("exit_out_valid", out_valid, 0);
      chk("exit_in_ready", in_ready, 1);
      g_p = 0;
      g_m = 0;
      g_n = 0;
   endtask

   initial begin
      bit closed;
      int n, p, m;

      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_last    = 1'b0;
      h_plus_32  = '0;
      h_minus_32 = '0;
      out_ready  = 1'b0;
      thr        = 0;
`ifdef COUNT_ACCUM_THRESH_EN
      thresh     = '0;
`endif
      g_p = 0; g_m = 0; g_n = 0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum_plus", sum_plus, 0);
      chk("rst_diff", diff, 0);
      chk("rst_beats", beats, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      idle(2);

      // Three-beat group: 47 / 9 / +38 / 3.
      beat(10, 2, 0, closed);
      beat(32, 0, 0, closed);
      beat(5, 7, 1, closed);
      chk("g1_sum_plus_const", sum_plus, 47);
      chk("g1_diff_const", diff, 38);
      release_result(2, 0, 0, 0, 0);

      // Single-beat negative group.
      beat(0, 32, 1, closed);
      chk("g2_diff_const", diff, -32);
      release_result(3, 0, 1, 1, 1);

      // Force-close at MAX_BEATS, beat 17 pending through a 5-cycle hold.
      for (int i = 0; i < MAX_BEATS; i++) beat(32, 32, 0, closed);
      chk("g3_overrun_const", overrun, 1);
      chk("g3_sum_plus_const", sum_plus, 512);
      release_result(5, 1, 32, 32, 1);
      beat(32, 32, 1, closed);
      chk("g4_beats_const", beats, 1);
      release_result(0, 0, 0, 0, 0);

      // Asynchronous reset mid-group discards partial totals.
      beat(7, 3, 0, closed);
      beat(9, 1, 0, closed);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_sum_plus", sum_plus, 0);
      chk("arst_sum_minus", sum_minus, 0);
      chk("arst_diff", diff, 0);
      chk("arst_beats", beats, 0);
      chk("arst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      g_p = 0; g_m = 0; g_n = 0;
      beat(4, 1, 1, closed);
      chk("post_rst_diff_const", diff, 3);
      release_result(1, 0, 0, 0, 0);

`ifdef COUNT_ACCUM_THRESH_EN
      thr = 10;
      beat(10, 0, 1, closed);
      chk("thr_eq_fire", fire, 1);
      release_result(1, 0, 0, 0, 0);
      beat(9, 0, 1, closed);
      chk("thr_below_fire", fire, 0);
      release_result(1, 0, 0, 0, 0);
      thr = -6;
      beat(0, 5, 1, closed);
      chk("thr_neg_fire", fire, 1);
      release_result(1, 0, 0, 0, 0);
`endif

      // Randomized groups with random lengths, gaps and hold times.
      for (int g = 0; g < 40; g++) begin
         thr = $urandom_range(0, 80) - 40;
         n   = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            if ($urandom_range(0, 7) == 0) begin
               p = $urandom_range(0, 127);
               m = $urandom_range(0, 127);
            end else begin
               p = $urandom_range(0, 32);
               m = $urandom_range(0, 32);
            end
            beat(p, m, (i == n - 1), closed);
            if (closed) break;
         end
         release_result($urandom_range(0, 3), 0,
                        $urandom_range(0, 32), $urandom_range(0, 32),
                        1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
